// File: rtl/ysyx_22051145_wb_arb.sv
// Write-back arbiter for the shared register-file write port plus a
// per-register pending-write scoreboard used by decode for RAW/WAW detection.
module ysyx_22051145_wb_arb #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned AW         = 5,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_waddr,
    input  logic [XLEN-1:0] a_wdata,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_waddr,
    input  logic [XLEN-1:0] b_wdata,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
    output logic [31:0]     busy_vec,
    output logic            rf_en_w,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int unsigned NREG = 32;
    localparam int unsigned CW   = 4;

    logic [CW-1:0]   starve_cnt;
    logic [CW-1:0]   starve_nxt;
    logic            grant_a;
    logic            grant_b;
    logic [AW-1:0]   sel_waddr;
    logic [XLEN-1:0] sel_wdata;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;

    // A wins ties until B has been passed over STARVE_MAX times in a row
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_valid && (!b_valid || (starve_cnt < CW'(STARVE_MAX)))) begin
            grant_a = 1'b1;
        end else if (b_valid) begin
            grant_b = 1'b1;
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_comb begin
        starve_nxt = starve_cnt;
        if (!b_valid || grant_b) begin
            starve_nxt = '0;
        end else if (grant_a && (starve_cnt < CW'(STARVE_MAX))) begin
            starve_nxt = starve_cnt + CW'(1);
        end
    end

    always_comb begin
        sel_waddr = a_waddr;
        sel_wdata = a_wdata;
        if (grant_b) begin
            sel_waddr = b_waddr;
            sel_wdata = b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
        end
    end

    // Registered write port; x0 writes are accepted but never enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_en_w  <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_en_w <= 1'b0;
            if (grant_a || grant_b) begin
                rf_en_w  <= (sel_waddr != '0);
                rf_waddr <= sel_waddr;
                rf_wdata <= sel_wdata;
            end
        end
    end

    // Clear lands with the register-file commit; a same-edge issue re-sets the bit
    always_comb begin
        busy_nxt = busy_q;
        if (rf_en_w) begin
            busy_nxt[rf_waddr] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy_vec = {busy_q[NREG-1:1], 1'b0};
    assign rs1_busy = busy_vec[chk_rs1];
    assign rs2_busy = busy_vec[chk_rs2];
    assign rd_busy  = busy_vec[iss_rd];

endmodule

// File: tb/tb_ysyx_22051145_wb_arb.sv
// Directed bench for the write-back arbiter: reset, handshake latency,
// starvation-bounded arbitration, x0 writes, set-wins scoreboard and lone-B grant.
module tb_ysyx_22051145_wb_arb;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_waddr;
    logic [63:0] a_wdata;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_waddr;
    logic [63:0] b_wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic [31:0] busy_vec;
    logic        rf_en_w;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    int unsigned vectors;
    int unsigned miscompares;
    logic        exp_a;
    logic [63:0] a_d;
    logic [63:0] b_d;

    ysyx_22051145_wb_arb #(.XLEN(64), .AW(5), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy), .busy_vec(busy_vec),
        .rf_en_w(rf_en_w), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        a_valid = 1'b0; a_waddr = '0; a_wdata = '0;
        b_valid = 1'b0; b_waddr = '0; b_wdata = '0;
        iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
        tick();
        tick();
        check("rst_busy_vec", 64'(busy_vec), 64'(0));
        check("rst_en_w", 64'(rf_en_w), 64'(0));
        check("rst_waddr", 64'(rf_waddr), 64'(0));
        check("rst_wdata", rf_wdata, 64'(0));
        rst = 1'b0;
        tick();

        // 1: mid-cycle async reset with busy[3] set and a write in the output stage
        iss_valid = 1'b1; iss_rd = 5'd3;
        a_valid = 1'b1; a_waddr = 5'd4; a_wdata = 64'h44;
        tick();
        iss_valid = 1'b0; a_valid = 1'b0;
        check("t1_busy3", 64'(busy_vec), 64'h8);
        check("t1_en_w_pre", 64'(rf_en_w), 64'(1));
        b_valid = 1'b1; b_waddr = 5'd9; b_wdata = 64'h99;
        #2;
        rst = 1'b1;
        #1;
        check("t1_rst_en_w", 64'(rf_en_w), 64'(0));
        check("t1_rst_busy", 64'(busy_vec), 64'(0));
        check("t1_rst_waddr", 64'(rf_waddr), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        check("t1_b_ready", 64'(b_ready), 64'(1));
        tick();
        b_valid = 1'b0;
        check("t1_b_waddr", 64'(rf_waddr), 64'(9));
        check("t1_b_wdata", rf_wdata, 64'h99);
        tick();

        // 2: issue rd=5, A writes it three cycles later
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        iss_valid = 1'b0;
        chk_rs1 = 5'd5;
        #1;
        check("t2_busy5", 64'(busy_vec), 64'h20);
        check("t2_rd_busy", 64'(rd_busy), 64'(1));
        check("t2_rs1_busy_set", 64'(rs1_busy), 64'(1));
        tick();
        tick();
        a_valid = 1'b1; a_waddr = 5'd5; a_wdata = 64'hDEAD_BEEF;
        #1;
        check("t2_a_ready", 64'(a_ready), 64'(1));
        check("t2_b_ready", 64'(b_ready), 64'(0));
        tick();
        a_valid = 1'b0;
        check("t2_en_w", 64'(rf_en_w), 64'(1));
        check("t2_waddr", 64'(rf_waddr), 64'(5));
        check("t2_wdata", rf_wdata, 64'hDEAD_BEEF);
        check("t2_busy5_held", 64'(busy_vec), 64'h20);
        tick();
        check("t2_busy5_clr", 64'(busy_vec), 64'(0));
        check("t2_rs1_busy_clr", 64'(rs1_busy), 64'(0));
        check("t2_en_w_off", 64'(rf_en_w), 64'(0));

        // 3: both requesters held valid for 8 transfers
        a_d = 64'hA000; b_d = 64'hB000;
        a_valid = 1'b1; a_waddr = 5'd10;
        b_valid = 1'b1; b_waddr = 5'd11;
        for (int i = 0; i < 8; i++) begin
            a_wdata = a_d;
            b_wdata = b_d;
            exp_a = ((i % 4) != 3);
            #1;
            check($sformatf("t3_a_ready_%0d", i), 64'(a_ready), 64'(exp_a));
            check($sformatf("t3_b_ready_%0d", i), 64'(b_ready), 64'(!exp_a));
            check($sformatf("t3_excl_%0d", i), 64'(a_ready & b_ready), 64'(0));
            tick();
            check($sformatf("t3_waddr_%0d", i), 64'(rf_waddr), exp_a ? 64'(10) : 64'(11));
            check($sformatf("t3_wdata_%0d", i), rf_wdata, exp_a ? a_d : b_d);
            if (exp_a) a_d = a_d + 64'(1);
            else       b_d = b_d + 64'(1);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        // 4: write to x0 is accepted but leaves the scoreboard alone
        iss_valid = 1'b1; iss_rd = 5'd12;
        tick();
        iss_valid = 1'b0;
        b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 64'h1234;
        #1;
        check("t4_b_ready", 64'(b_ready), 64'(1));
        tick();
        b_valid = 1'b0;
        check("t4_en_w", 64'(rf_en_w), 64'(0));
        check("t4_wdata", rf_wdata, 64'h1234);
        check("t4_busy", 64'(busy_vec), 64'h1000);
        tick();
        check("t4_busy_after", 64'(busy_vec), 64'h1000);

        // 5: clear and re-issue of x7 on the same edge, set wins
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        a_valid = 1'b1; a_waddr = 5'd7; a_wdata = 64'h77;
        tick();
        a_valid = 1'b0;
        check("t5_en_w", 64'(rf_en_w), 64'(1));
        check("t5_waddr", 64'(rf_waddr), 64'(7));
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        check("t5_rd_busy", 64'(rd_busy), 64'(1));
        tick();
        iss_valid = 1'b0;
        chk_rs2 = 5'd7;
        #1;
        check("t5_busy", 64'(busy_vec), 64'h1080);
        check("t5_rs2_busy", 64'(rs2_busy), 64'(1));

        // 6: lone B request, starvation counter stays at zero
        b_valid = 1'b1; b_waddr = 5'd12; b_wdata = 64'hC0FFEE;
        #1;
        check("t6_b_ready", 64'(b_ready), 64'(1));
        check("t6_a_ready", 64'(a_ready), 64'(0));
        tick();
        b_valid = 1'b0;
        check("t6_starve", 64'(dut.starve_cnt), 64'(0));
        check("t6_en_w", 64'(rf_en_w), 64'(1));
        check("t6_waddr", 64'(rf_waddr), 64'(12));
        check("t6_wdata", rf_wdata, 64'hC0FFEE);
        tick();
        check("t6_en_w_pulse", 64'(rf_en_w), 64'(0));
        check("t6_busy", 64'(busy_vec), 64'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
